// File: rtl/speed_clk_gen.sv
// Speed-select clock front end: four free-running dividers, speed switch synchronizer,
// debounced pause/run toggle. Optional macro SPEED_CHANGE_PAUSE_EN forces PAUSE on a speed change.
module speed_clk_gen #(
    parameter int HALF0     = 25000000,
    parameter int HALF1     = 12500000,
    parameter int HALF2     = 6250000,
    parameter int HALF3     = 3125000,
    parameter int DB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause,
    input  logic [1:0] sw_in,
    output logic [3:0] clk_div,
    output logic [1:0] sw_sync,
    output logic       En
);

    localparam int DCW = $clog2(DB_CYCLES);
    localparam logic [0:0] ST_PAUSE = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [1:0]     sw_meta_r;
    logic [1:0]     sw_sync_r;
    logic           btn_meta_r;
    logic           btn_s2_r;
    logic [DCW-1:0] dcnt_r;
    logic           db_level_r;
    logic           db_d_r;
    logic           press_evt_s;
    logic           spd_chg_s;
    logic [0:0]     state_r;
    logic [0:0]     state_nxt_s;
    logic           en_r;

    for (genvar i = 0; i < 4; i++) begin : g_div
        localparam int HALF = (i == 0) ? HALF0 : (i == 1) ? HALF1 : (i == 2) ? HALF2 : HALF3;
        localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

        logic [CW-1:0] cnt_r;
        logic          tog_r;

        // Half-period counter; the output toggles on the wrap edge
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r <= {CW{1'b0}};
                tog_r <= 1'b0;
            end else if (cnt_r == CW'(HALF - 1)) begin
                cnt_r <= {CW{1'b0}};
                tog_r <= ~tog_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end

        assign clk_div[i] = tog_r;
    end

    // Two-flop synchronizers for the speed switch and the raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_r  <= 2'b00;
            sw_sync_r  <= 2'b00;
            btn_meta_r <= 1'b0;
            btn_s2_r   <= 1'b0;
        end else begin
            sw_meta_r  <= sw_in;
            sw_sync_r  <= sw_meta_r;
            btn_meta_r <= btn_pause;
            btn_s2_r   <= btn_meta_r;
        end
    end

    // Debounce: a new level is accepted only after DB_CYCLES unbroken disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_r     <= {DCW{1'b0}};
            db_level_r <= 1'b0;
            db_d_r     <= 1'b0;
        end else begin
            db_d_r <= db_level_r;
            if (btn_s2_r == db_level_r) begin
                dcnt_r <= {DCW{1'b0}};
            end else if (dcnt_r == DCW'(DB_CYCLES - 1)) begin
                db_level_r <= btn_s2_r;
                dcnt_r     <= {DCW{1'b0}};
            end else begin
                dcnt_r <= dcnt_r + DCW'(1);
            end
        end
    end

    assign press_evt_s = db_level_r & ~db_d_r;

`ifdef SPEED_CHANGE_PAUSE_EN
    logic [1:0] sw_prev_r;

    // Previous synchronized speed, used to detect a speed change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_prev_r <= 2'b00;
        end else begin
            sw_prev_r <= sw_sync_r;
        end
    end

    assign spd_chg_s = (sw_sync_r != sw_prev_r);
`else
    assign spd_chg_s = 1'b0;
`endif

    // Pause/run next state; a speed change in RUN overrides a simultaneous press
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_PAUSE: begin
                if (press_evt_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_RUN: begin
                if (press_evt_s || spd_chg_s) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_PAUSE;
        endcase
    end

    // State register; En is registered from the next state so it always mirrors the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_PAUSE;
            en_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            en_r    <= (state_nxt_s == ST_RUN);
        end
    end

    assign sw_sync = sw_sync_r;
    assign En      = en_r;

endmodule

// File: tb/tb_speed_clk_gen.sv
// Self-checking bench for speed_clk_gen with small divider/debounce parameters.
module tb_speed_clk_gen;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_pause = 1'b0;
    logic [1:0] sw_in = 2'b00;
    logic [3:0] clk_div;
    logic [1:0] sw_sync;
    logic       En;

    int n_chk = 0;
    int n_fail = 0;

    int         half_a [4] = '{1, 2, 3, 4};
    int         n_edge;
    logic       bh[$];
    logic [1:0] sh[$];
    logic       m_lvl, m_rose, m_en;
    logic [3:0] m_div;
    logic [1:0] m_sw;

    speed_clk_gen #(.HALF0(1), .HALF1(2), .HALF2(3), .HALF3(4), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .btn_pause(btn_pause), .sw_in(sw_in),
        .clk_div(clk_div), .sw_sync(sw_sync), .En(En)
    );

    always #5 clk = ~clk;

    // synchronized button value seen just before edge n (two edges of delay)
    function automatic logic s2_before(int n);
        int k = n - 3;
        if (k < 0 || k >= bh.size()) return 1'b0;
        return bh[k];
    endfunction

    // synchronized switch value just after edge n
    function automatic logic [1:0] sw_after(int n);
        int k = n - 2;
        if (k < 0 || k >= sh.size()) return 2'b00;
        return sh[k];
    endfunction

    task automatic model_reset();
        n_edge = 0; bh.delete(); sh.delete();
        m_lvl = 1'b0; m_rose = 1'b0; m_en = 1'b0; m_div = 4'b0000; m_sw = 2'b00;
    endtask

    task automatic model_edge(input logic b, input logic [1:0] s);
        logic all_diff;
        logic chg;
        n_edge++;
        bh.push_back(b);
        sh.push_back(s);
        chg = 1'b0;
`ifdef SPEED_CHANGE_PAUSE_EN
        chg = (sw_after(n_edge - 1) != sw_after(n_edge - 2));
`endif
        if (m_en && chg) m_en = 1'b0;
        else if (m_rose) m_en = ~m_en;
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++)
            if (s2_before(n_edge - j) == m_lvl) all_diff = 1'b0;
        m_rose = all_diff && !m_lvl;
        if (all_diff) m_lvl = ~m_lvl;
        m_sw = sw_after(n_edge);
        for (int i = 0; i < 4; i++) m_div[i] = ((n_edge / half_a[i]) % 2) != 0;
    endtask

    task automatic tick(input logic b, input logic [1:0] s);
        btn_pause = b;
        sw_in = s;
        @(posedge clk);
        model_edge(b, s);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_chk++;
        if ({clk_div, sw_sync, En} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset: got div=%b sw=%b En=%b, expected all zero", clk_div, sw_sync, En);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_dividers();
        int first_rise3 = -1;
        for (int t = 1; t <= 24; t++) begin
            tick(1'b0, 2'b00);
            if (first_rise3 < 0 && clk_div[3]) first_rise3 = t;
            n_chk++;
            if ({clk_div, sw_sync, En} !== {m_div, m_sw, m_en}) begin
                n_fail++;
                $display("FAIL dividers edge %0d: got div=%b sw=%b En=%b, expected div=%b sw=%b En=%b",
                         t, clk_div, sw_sync, En, m_div, m_sw, m_en);
            end
        end
        n_chk++;
        if (first_rise3 !== 4) begin
            n_fail++;
            $display("FAIL div3_first_rise: got edge %0d, expected edge 4", first_rise3);
        end
    endtask

    task automatic test_press();
        int rise_at = -1;
        for (int t = 0; t < 20; t++) begin
            tick(t < 10, 2'b00);
            if (rise_at < 0 && En) rise_at = t;
            n_chk++;
            if ({clk_div, sw_sync, En} !== {m_div, m_sw, m_en}) begin
                n_fail++;
                $display("FAIL press t=%0d: got div=%b sw=%b En=%b, expected div=%b sw=%b En=%b",
                         t, clk_div, sw_sync, En, m_div, m_sw, m_en);
            end
        end
        n_chk++;
        if (rise_at !== DB + 2 || En !== 1'b1) begin
            n_fail++;
            $display("FAIL press_latency: got rise at %0d En=%b, expected rise at %0d En=1",
                     rise_at, En, DB + 2);
        end
    endtask

    task automatic test_glitch();
        logic pat [24] = '{1,1,1,0,0,0,0,0,0,0, 1,0,1,0,1,0,1,0,1,0, 0,0,0,0};
        for (int t = 0; t < 24; t++) begin
            tick(pat[t], 2'b00);
            n_chk++;
            if (En !== m_en || En !== 1'b1) begin
                n_fail++;
                $display("FAIL glitch t=%0d: got En=%b, expected En=%b (unchanged 1)", t, En, m_en);
            end
        end
    endtask

    task automatic test_second_press_sw();
        int fall_at = -1;
        for (int t = 0; t < 20; t++) begin
            tick(t < 10, (t >= 12) ? 2'b11 : 2'b00);
            if (fall_at < 0 && !En) fall_at = t;
            if (t == 12 || t == 13) begin
                n_chk++;
                if (sw_sync !== ((t == 13) ? 2'b11 : 2'b00)) begin
                    n_fail++;
                    $display("FAIL sw_latency t=%0d: got sw_sync=%b, expected %b", t, sw_sync,
                             (t == 13) ? 2'b11 : 2'b00);
                end
            end
            n_chk++;
            if ({clk_div, sw_sync, En} !== {m_div, m_sw, m_en}) begin
                n_fail++;
                $display("FAIL second_press t=%0d: got div=%b sw=%b En=%b, expected div=%b sw=%b En=%b",
                         t, clk_div, sw_sync, En, m_div, m_sw, m_en);
            end
        end
        n_chk++;
        if (fall_at !== DB + 2) begin
            n_fail++;
            $display("FAIL second_press_latency: got fall at %0d, expected %0d", fall_at, DB + 2);
        end
    endtask

    task automatic test_async_reset();
        for (int t = 0; t < 8; t++) tick(1'b1, 2'b11);
        tick(1'b0, 2'b11);
        tick(1'b0, 2'b11);
        n_chk++;
        if (En !== 1'b1 || En !== m_en) begin
            n_fail++;
            $display("FAIL pre_reset_run: got En=%b, expected 1", En);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({clk_div, sw_sync, En} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset: got div=%b sw=%b En=%b, expected all zero", clk_div, sw_sync, En);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_chk++;
        if ({clk_div, sw_sync, En} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got div=%b sw=%b En=%b, expected all zero", clk_div, sw_sync, En);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int t = 1; t <= 12; t++) begin
            tick(1'b0, 2'b00);
            n_chk++;
            if ({clk_div, sw_sync, En} !== {m_div, m_sw, m_en}) begin
                n_fail++;
                $display("FAIL post_reset edge %0d: got div=%b sw=%b En=%b, expected div=%b sw=%b En=%b",
                         t, clk_div, sw_sync, En, m_div, m_sw, m_en);
            end
        end
    endtask

    task automatic test_random();
        logic       b = 1'b0;
        logic [1:0] s = 2'b00;
        int         run = 0;
        for (int t = 0; t < 500; t++) begin
            if (run == 0) begin
                b = ~b;
                run = $urandom_range(DB + 4, 1);
            end
            run--;
            if ($urandom_range(15, 0) == 0) s = 2'($urandom_range(3, 0));
            tick(b, s);
            n_chk++;
            if ({clk_div, sw_sync, En} !== {m_div, m_sw, m_en}) begin
                n_fail++;
                $display("FAIL random t=%0d: got div=%b sw=%b En=%b, expected div=%b sw=%b En=%b",
                         t, clk_div, sw_sync, En, m_div, m_sw, m_en);
            end
        end
        for (int t = 0; t < 12; t++) tick(1'b0, s);
    endtask

    task automatic test_speed_change();
        logic exp_en;
        if (!m_en) for (int t = 0; t < 12; t++) tick(t < 8, sw_sync);
        for (int t = 0; t < 4; t++) tick(1'b0, 2'b00);
        tick(1'b0, 2'b10);
        tick(1'b0, 2'b10);
        n_chk++;
        if (sw_sync !== 2'b10) begin
            n_fail++;
            $display("FAIL spd_sw_sync: got %b, expected 10", sw_sync);
        end
        tick(1'b0, 2'b10);
`ifdef SPEED_CHANGE_PAUSE_EN
        exp_en = 1'b0;
`else
        exp_en = 1'b1;
`endif
        n_chk++;
        if (En !== exp_en || En !== m_en) begin
            n_fail++;
            $display("FAIL spd_change_en: got En=%b, expected %b", En, exp_en);
        end
        if (!m_en) for (int t = 0; t < 12; t++) tick(t < 8, 2'b10);
        for (int t = 0; t < 10; t++) begin
            tick(1'b1, (t >= 4) ? 2'b01 : 2'b10);
            n_chk++;
            if ({clk_div, sw_sync, En} !== {m_div, m_sw, m_en}) begin
                n_fail++;
                $display("FAIL spd_same_cycle t=%0d: got div=%b sw=%b En=%b, expected div=%b sw=%b En=%b",
                         t, clk_div, sw_sync, En, m_div, m_sw, m_en);
            end
        end
        n_chk++;
        if (En !== 1'b0) begin
            n_fail++;
            $display("FAIL spd_same_cycle_final: got En=%b, expected 0", En);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_dividers();
        test_press();
        test_glitch();
        test_second_press_sw();
        test_async_reset();
        test_random();
        test_speed_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
